apb_uart_arbiter: RTL

Two-requester APB master that shares the single APB port of the UART register interface between two local initiators. Examples are a boot-time configuration sequencer and a host command path. Each requester issues single read/write transfers through a valid/ready request channel and receives a one-cycle response pulse. The block arbitrates round-robin, generates compliant SETUP/ACCESS phases, honours PREADY wait states, and aborts hung transfers with a timeout error.

---
 rtl/uart_apb_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 30 +++
 rtl/apb_uart_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/uart_apb_pkg.sv
// Shared types and constants for the UART APB master arbiter.
// Error codes are internal detail; the requester ports carry only one err bit.
package uart_apb_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        ERR_RSP
    } apb_state_e;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_BUS,
        ERR_TIMEOUT,
        ERR_ALIGN
    } apb_err_e;

    function automatic logic is_aligned(input logic [APB_AW-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic last_grant;

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || last_grant)) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end

    // Reset value 1 lets requester 0 take the first tie.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/apb_uart_arbiter.sv
// Shares one APB master port between two valid/ready requesters with
// round-robin arbitration, PREADY wait states and an ACCESS-phase timeout.
module apb_uart_arbiter
    import uart_apb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [APB_AW-1:0] req0_addr,
    input  logic [APB_DW-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [APB_DW-1:0] rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [APB_AW-1:0] req1_addr,
    input  logic [APB_DW-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [APB_DW-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [APB_AW-1:0] PADDR,
    output logic [APB_DW-1:0] PWDATA,
    input  logic [APB_DW-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    apb_state_e        state;
    logic              owner;
    logic [CNT_W-1:0]  wait_cnt;
    logic [1:0]        gnt;
    logic              accept;
    logic              timeout_hit;
    logic [APB_AW-1:0] sel_addr;
    logic [APB_DW-1:0] sel_wdata;
    logic              sel_write;
    logic              done;
    apb_err_e          done_code;
    logic [APB_DW-1:0] done_rdata;

    rr_arb2 u_arb (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .req     ({req1_valid, req0_valid}),
        .accept  (accept),
        .gnt     (gnt)
    );

    assign accept     = (state == IDLE) && (gnt != 2'b00);
    assign req0_ready = PRESETn && accept && gnt[0];
    assign req1_ready = PRESETn && accept && gnt[1];

    assign sel_addr  = gnt[1] ? req1_addr  : req0_addr;
    assign sel_wdata = gnt[1] ? req1_wdata : req0_wdata;
    assign sel_write = gnt[1] ? req1_write : req0_write;

    // Abort on the edge where the T-th consecutive wait state would be counted.
    assign timeout_hit = (TIMEOUT != 0) && !PREADY && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        done       = 1'b0;
        done_code  = ERR_NONE;
        done_rdata = '0;
        case (state)
            ACCESS: begin
                if (PREADY) begin
                    done = 1'b1;
                    if (PSLVERR) begin
                        done_code = ERR_BUS;
                    end else if (!PWRITE) begin
                        done_rdata = PRDATA;
                    end
                end else if (timeout_hit) begin
                    done      = 1'b1;
                    done_code = ERR_TIMEOUT;
                end
            end
            ERR_RSP: begin
                done      = 1'b1;
                done_code = ERR_ALIGN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= IDLE;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            PWRITE   <= 1'b0;
            PADDR    <= '0;
            PWDATA   <= '0;
            owner    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner <= gnt[1];
                        if (is_aligned(sel_addr)) begin
                            PADDR  <= sel_addr;
                            PWDATA <= sel_wdata;
                            PWRITE <= sel_write;
                            PSEL   <= 1'b1;
                            state  <= SETUP;
                        end else begin
                            state <= ERR_RSP;
                        end
                    end
                end
                SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        PSEL     <= 1'b0;
                        PENABLE  <= 1'b0;
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ERR_RSP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Only the owner's response registers move; the other side keeps its last response.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
            rsp1_err   <= 1'b0;
        end else begin
            rsp0_valid <= done && !owner;
            rsp1_valid <= done && owner;
            if (done && !owner) begin
                rsp0_rdata <= done_rdata;
                rsp0_err   <= (done_code != ERR_NONE);
            end
            if (done && owner) begin
                rsp1_rdata <= done_rdata;
                rsp1_err   <= (done_code != ERR_NONE);
            end
        end
    end

endmodule
